// File: rtl/ahb_arb_pkg.sv
// Shared AHB encodings and helpers for the three-master arbiter.
package ahb_arb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'd0,
        TR_BUSY   = 2'd1,
        TR_NONSEQ = 2'd2,
        TR_SEQ    = 2'd3
    } htrans_e;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'd0,
        BU_INCR   = 3'd1,
        BU_WRAP4  = 3'd2,
        BU_INCR4  = 3'd3,
        BU_WRAP8  = 3'd4,
        BU_INCR8  = 3'd5,
        BU_WRAP16 = 3'd6,
        BU_INCR16 = 3'd7
    } hburst_e;

    localparam logic [1:0] RESP_ERROR = 2'd1;

    function automatic logic [4:0] burst_beats(
        input logic [2:0] hburst
    );
        logic [4:0] n;
        case (hburst)
            BU_WRAP4, BU_INCR4:   n = 5'd3;
            BU_WRAP8, BU_INCR8:   n = 5'd7;
            BU_WRAP16, BU_INCR16: n = 5'd15;
            default:              n = 5'd0;
        endcase
        return n;
    endfunction

    function automatic logic [1:0] next_idx(
        input logic [1:0] i
    );
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [1:0] oh2idx(
        input logic [2:0] oh
    );
        logic [1:0] i;
        unique case (1'b1)
            oh[0]:   i = 2'd0;
            oh[1]:   i = 2'd1;
            oh[2]:   i = 2'd2;
            default: i = 2'd0;
        endcase
        return i;
    endfunction

endpackage

// File: rtl/ahb_arbiter_m3_if.sv
// Arbiter bus bundle: requests and muxed bus status in,
// grants and ownership indices out.
interface ahb_arbiter_m3_if;

    logic       HBUSREQ0;
    logic       HBUSREQ1;
    logic       HBUSREQ2;
    logic       HLOCK0;
    logic       HLOCK1;
    logic       HLOCK2;
    logic       HGRANT0;
    logic       HGRANT1;
    logic       HGRANT2;
    logic [1:0] HMASTER;
    logic [1:0] HMASTER_D;
    logic       HMASTLOCK;
    logic       HREADY;
    logic [1:0] HTRANS;
    logic [2:0] HBURST;
    logic [1:0] HRESP;

    modport master (
        output HBUSREQ0, HBUSREQ1, HBUSREQ2,
        output HLOCK0, HLOCK1, HLOCK2,
        output HREADY, HTRANS, HBURST, HRESP,
        input  HGRANT0, HGRANT1, HGRANT2,
        input  HMASTER, HMASTER_D, HMASTLOCK
    );

    modport slave (
        input  HBUSREQ0, HBUSREQ1, HBUSREQ2,
        input  HLOCK0, HLOCK1, HLOCK2,
        input  HREADY, HTRANS, HBURST, HRESP,
        output HGRANT0, HGRANT1, HGRANT2,
        output HMASTER, HMASTER_D, HMASTLOCK
    );

endinterface

// File: rtl/ahb_arb_pick.sv
// Combinational 3-way picker: first requester from start,
// wrapping; falls back to the default index when idle.
module ahb_arb_pick
    import ahb_arb_pkg::*;
(
    input  logic [2:0] req,
    input  logic [1:0] start,
    input  logic [1:0] dflt,
    output logic [2:0] gnt
);

    logic       found;
    logic [1:0] idx;

    always_comb begin
        gnt   = '0;
        found = 1'b0;
        idx   = start;
        for (int k = 0; k < 3; k++) begin
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                found    = 1'b1;
            end
            idx = next_idx(idx);
        end
        if (!found) gnt[dflt] = 1'b1;
    end

endmodule

// File: rtl/ahb_arbiter_m3.sv
// Three-master AHB arbiter with burst and lock awareness.
// ARB_ROUND_ROBIN_EN selects rotating priority over fixed.
module ahb_arbiter_m3
    import ahb_arb_pkg::*;
#(
    parameter int DEFAULT_MASTER = 0
) (
    input logic             HCLK,
    input logic             HRESETn,
    ahb_arbiter_m3_if.slave bus
);

    localparam logic [1:0] DFLT = 2'(DEFAULT_MASTER);
    localparam logic [2:0] DFLT_OH = 3'(1 << DEFAULT_MASTER);

    logic [2:0] req;
    logic [2:0] lock;
    logic [2:0] gnt_q;
    logic [2:0] gnt_pick;
    logic [1:0] mst_q;
    logic [1:0] mst_d_q;
    logic       mlock_q;
    logic [4:0] cnt_q;
    logic [4:0] cnt_d;
    logic       open_q;
    logic       open_d;
    logic [1:0] cur_idx;
    logic [1:0] start;
    logic       own_req;
    logic       own_lock;
    logic       err;
    logic       last_beat;
    logic       arb_ok;

    assign req  = {bus.HBUSREQ2, bus.HBUSREQ1, bus.HBUSREQ0};
    assign lock = {bus.HLOCK2, bus.HLOCK1, bus.HLOCK0};

    assign cur_idx  = oh2idx(gnt_q);
    assign own_req  = req[mst_q];
    assign own_lock = lock[mst_q];
    assign err      = (bus.HRESP == RESP_ERROR);

    always_comb begin
        cnt_d     = cnt_q;
        open_d    = open_q;
        last_beat = 1'b0;
        arb_ok    = 1'b0;
        case (bus.HTRANS)
            TR_NONSEQ: begin
                cnt_d  = burst_beats(bus.HBURST);
                open_d = (bus.HBURST == BU_INCR);
            end
            // Saturate so an open INCR never wraps the counter
            TR_SEQ:  if (cnt_q != 5'd0) cnt_d = cnt_q - 5'd1;
            TR_IDLE: open_d = 1'b0;
            default: ;
        endcase
        if (bus.HTRANS[1])
            last_beat = (cnt_d == 5'd0) && !open_d;
        if (err) begin
            cnt_d  = 5'd0;
            open_d = 1'b0;
        end
        arb_ok = (bus.HTRANS == TR_IDLE) || last_beat
               || (open_q && !own_req) || err;
        if (own_lock && own_req) arb_ok = 1'b0;
    end

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] ptr_q;

    assign start = next_idx(ptr_q);

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn)
            ptr_q <= DFLT;
        else if (bus.HREADY && arb_ok)
            ptr_q <= oh2idx(gnt_pick);
    end
`else
    assign start = 2'd0;
`endif

    ahb_arb_pick u_pick (
        .req   (req),
        .start (start),
        .dflt  (DFLT),
        .gnt   (gnt_pick)
    );

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            gnt_q   <= DFLT_OH;
            mst_q   <= DFLT;
            mst_d_q <= DFLT;
            mlock_q <= 1'b0;
            cnt_q   <= 5'd0;
            open_q  <= 1'b0;
        end else if (bus.HREADY) begin
            cnt_q   <= cnt_d;
            open_q  <= open_d;
            if (arb_ok) gnt_q <= gnt_pick;
            mst_q   <= cur_idx;
            mlock_q <= lock[cur_idx];
            mst_d_q <= mst_q;
        end
    end

    assign bus.HGRANT0   = gnt_q[0];
    assign bus.HGRANT1   = gnt_q[1];
    assign bus.HGRANT2   = gnt_q[2];
    assign bus.HMASTER   = mst_q;
    assign bus.HMASTER_D = mst_d_q;
    assign bus.HMASTLOCK = mlock_q;

endmodule

// File: tb/tb_ahb_arbiter_m3.sv
// Directed vector bench for ahb_arbiter_m3.
module tb_ahb_arbiter_m3;
    import ahb_arb_pkg::*;

    logic HCLK = 1'b0;
    logic HRESETn = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 HCLK = ~HCLK;

    ahb_arbiter_m3_if bus ();

    ahb_arbiter_m3 #(.DEFAULT_MASTER(0)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    // exp = {grant[2:0], HMASTER, HMASTER_D, HMASTLOCK, cnt[4:0]}
    typedef struct {
        logic [2:0]  req;
        logic [2:0]  lck;
        logic        rdy;
        logic [1:0]  tr;
        logic [2:0]  bu;
        logic [1:0]  rs;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(
        input logic [2:0] req, lck,
        input logic rdy,
        input logic [1:0] tr,
        input logic [2:0] bu,
        input logic [1:0] rs,
        input logic [2:0] g,
        input logic [1:0] m, md,
        input logic ml,
        input logic [4:0] c
    );
        vec_t v;
        v.req = req;
        v.lck = lck;
        v.rdy = rdy;
        v.tr  = tr;
        v.bu  = bu;
        v.rs  = rs;
        v.exp = {g, m, md, ml, c};
        return v;
    endfunction

    function automatic logic [12:0] obs();
        return {bus.HGRANT2, bus.HGRANT1, bus.HGRANT0,
                bus.HMASTER, bus.HMASTER_D, bus.HMASTLOCK,
                dut.cnt_q};
    endfunction

    task automatic drive(input vec_t v);
        bus.HBUSREQ0 = v.req[0];
        bus.HBUSREQ1 = v.req[1];
        bus.HBUSREQ2 = v.req[2];
        bus.HLOCK0   = v.lck[0];
        bus.HLOCK1   = v.lck[1];
        bus.HLOCK2   = v.lck[2];
        bus.HREADY   = v.rdy;
        bus.HTRANS   = v.tr;
        bus.HBURST   = v.bu;
        bus.HRESP    = v.rs;
    endtask

    task automatic check(
        input string nm,
        input logic [12:0] act, exp
    );
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input string nm);
        @(negedge HCLK);
        drive(v);
        @(posedge HCLK);
        #1;
        check(nm, obs(), v.exp);
    endtask

    localparam logic [1:0] I = TR_IDLE;
    localparam logic [1:0] B = TR_BUSY;
    localparam logic [1:0] N = TR_NONSEQ;
    localparam logic [1:0] S = TR_SEQ;
    localparam logic [2:0] SG = BU_SINGLE;
    localparam logic [2:0] IN = BU_INCR;
    localparam logic [2:0] I4 = BU_INCR4;
    localparam logic [2:0] W8 = BU_WRAP8;
    localparam logic [2:0] I8 = BU_INCR8;
    localparam logic [1:0] ER = RESP_ERROR;

    logic [2:0] rr_exp [4];

    initial begin
        // reset release with nobody requesting
        tbl.push_back(mk(0, 0, 1, I, SG, 0, 1, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, I, SG, 0, 1, 0, 0, 0, 0));
        // master1 INCR4, master2 waits for the last beat
        tbl.push_back(mk(2, 0, 1, I, SG, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 1, I, SG, 0, 2, 1, 0, 0, 0));
        tbl.push_back(mk(6, 0, 1, N, I4, 0, 2, 1, 1, 0, 3));
        tbl.push_back(mk(6, 0, 1, S, I4, 0, 2, 1, 1, 0, 2));
        tbl.push_back(mk(6, 0, 1, S, I4, 0, 2, 1, 1, 0, 1));
        tbl.push_back(mk(4, 0, 1, S, I4, 0, 4, 1, 1, 0, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(4, 0, 0, I, SG, 0, 4, 1, 1, 0, 0));
        tbl.push_back(mk(4, 0, 1, I, SG, 0, 4, 2, 1, 0, 0));
        tbl.push_back(mk(4, 0, 1, I, SG, 0, 4, 2, 2, 0, 0));
        // master2 INCR4 stalled on its last beat
        tbl.push_back(mk(4, 0, 1, N, I4, 0, 4, 2, 2, 0, 3));
        tbl.push_back(mk(4, 0, 1, S, I4, 0, 4, 2, 2, 0, 2));
        tbl.push_back(mk(4, 0, 1, S, I4, 0, 4, 2, 2, 0, 1));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(1, 0, 0, S, I4, 0, 4, 2, 2, 0, 1));
        tbl.push_back(mk(1, 0, 1, S, I4, 0, 1, 2, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, I, SG, 0, 1, 0, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, I, SG, 0, 1, 0, 0, 0, 0));
        // master0 locked INCR8 then SINGLE, master1 requesting
        tbl.push_back(mk(3, 1, 1, N, I8, 0, 1, 0, 0, 1, 7));
        for (int k = 6; k >= 0; k--)
            tbl.push_back(mk(3, 1, 1, S, I8, 0, 1, 0, 0, 1,
                             5'(k)));
        tbl.push_back(mk(3, 1, 1, N, SG, 0, 1, 0, 0, 1, 0));
        tbl.push_back(mk(2, 0, 1, I, SG, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(2, 0, 1, I, SG, 0, 2, 1, 0, 0, 0));
        // ERROR on beat 2 of WRAP8
        tbl.push_back(mk(6, 0, 1, N, W8, 0, 2, 1, 1, 0, 7));
        tbl.push_back(mk(4, 0, 1, S, W8, ER, 4, 1, 1, 0, 0));
        tbl.push_back(mk(4, 0, 1, I, SG, 0, 4, 2, 1, 0, 0));
        // open INCR released by dropping HBUSREQ
        tbl.push_back(mk(4, 0, 1, N, IN, 0, 4, 2, 2, 0, 0));
        tbl.push_back(mk(5, 0, 1, S, IN, 0, 4, 2, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, B, IN, 0, 1, 2, 2, 0, 0));
        tbl.push_back(mk(1, 0, 1, I, SG, 0, 1, 0, 2, 0, 0));
        // default master on no request
        tbl.push_back(mk(2, 0, 1, I, SG, 0, 2, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, I, SG, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(0, 0, 1, I, SG, 0, 1, 0, 1, 0, 0));
        // burst in flight before the async reset below
        tbl.push_back(mk(2, 3, 1, N, I4, 0, 1, 0, 0, 1, 3));
        tbl.push_back(mk(2, 3, 1, S, I4, 0, 1, 0, 0, 1, 2));

`ifdef ARB_ROUND_ROBIN_EN
        rr_exp = '{3'b010, 3'b100, 3'b001, 3'b010};
`else
        rr_exp = '{3'b001, 3'b001, 3'b001, 3'b001};
`endif

        drive(mk(0, 0, 1, I, SG, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge HCLK);
        #1;
        check("reset_hold", obs(), 13'b001_00_00_0_00000);
        @(negedge HCLK);
        HRESETn = 1'b1;

        foreach (tbl[i])
            apply(tbl[i], $sformatf("vec%0d", i));

        @(negedge HCLK);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_reset", obs(), 13'b001_00_00_0_00000);
        @(negedge HCLK);
        HRESETn = 1'b1;

        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            drive(mk(7, 0, 1, N, SG, 0, 0, 0, 0, 0, 0));
            @(posedge HCLK);
            #1;
            check($sformatf("rr%0d", k), {obs() >> 10, 10'd0},
                  {rr_exp[k], 10'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_err);
        $finish;
    end

endmodule
